// File: rtl/audio_pkg.sv
// Shared audio-path definitions: sample width, default clock/sample rates, pacer states.
package audio_pkg;

  localparam int DATA_W     = 16;
  localparam int CLK_HZ_DEF = 50_000_000;
  localparam int FS_HZ_DEF  = 44_100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } pacer_state_t;

  // Wide enough to hold acc + FS_HZ before the wrap compare.
  function automatic int acc_width(input int clk_hz, input int fs_hz);
    return $clog2(clk_hz + fs_hz);
  endfunction

endpackage

// File: rtl/fs_tick_gen.sv
// Fractional rate divider: one-cycle registered tick, exactly FS_HZ ticks per CLK_HZ cycles.
// Latency: tick registered; no backpressure (free-running).
module fs_tick_gen #(
  parameter int CLK_HZ = audio_pkg::CLK_HZ_DEF,
  parameter int FS_HZ  = audio_pkg::FS_HZ_DEF
) (
  input  logic aclk,
  input  logic areset,
  output logic tick
);
  import audio_pkg::*;

  localparam int AW = acc_width(CLK_HZ, FS_HZ);
  localparam int SW = AW + 1;
  localparam logic [SW-1:0] FS_W  = SW'(FS_HZ);
  localparam logic [SW-1:0] CLK_W = SW'(CLK_HZ);

  logic [AW-1:0] acc;
  logic [SW-1:0] sum;

  assign sum = {1'b0, acc} + FS_W;

  always_ff @(posedge aclk) begin
    if (areset) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (sum >= CLK_W) begin
      acc  <= AW'(sum - CLK_W);
      tick <= 1'b1;
    end else begin
      acc  <= AW'(sum);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/audio_sample_pacer.sv
// Buffers bursty samples in a FIFO and releases one per audio-rate tick; 1 cycle tick-to-valid.
// Backpressure: s_tready = !full; a stalled output drops further ticks and flags them as late.
module audio_sample_pacer #(
  parameter int DATA_W = audio_pkg::DATA_W,
  parameter int DEPTH  = 16,
  parameter int CLK_HZ = audio_pkg::CLK_HZ_DEF,
  parameter int FS_HZ  = audio_pkg::FS_HZ_DEF
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       s_axis_data_tvalid,
  output logic                       s_axis_data_tready,
  input  logic [DATA_W-1:0]          s_axis_data_tdata,
  output logic                       m_axis_data_tvalid,
  input  logic                       m_axis_data_tready,
  output logic [DATA_W-1:0]          m_axis_data_tdata,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       underrun,
  output logic                       late
);
  import audio_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic              tick;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [LW-1:0]     level;
  logic              push;
  logic              pop;
  logic              underrun_nxt;
  logic              late_nxt;
  pacer_state_t      state;
  pacer_state_t      state_nxt;

  fs_tick_gen #(
    .CLK_HZ (CLK_HZ),
    .FS_HZ  (FS_HZ)
  ) u_tick (
    .aclk   (aclk),
    .areset (areset),
    .tick   (tick)
  );

  // Ready comes from the registered level only, so a same-cycle pop never admits a push when full.
  assign s_axis_data_tready = (level != LW'(DEPTH));
  assign push               = s_axis_data_tvalid && s_axis_data_tready;
  assign fifo_level         = level;
  assign m_axis_data_tvalid = (state == ST_HOLD);

  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    underrun_nxt = 1'b0;
    late_nxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tick) begin
          if (level != '0) begin
            pop       = 1'b1;
            state_nxt = ST_HOLD;
          end else begin
            underrun_nxt = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        // A tick coinciding with the handshake is still late: one sample per tick, never two.
        if (m_axis_data_tready) state_nxt = ST_IDLE;
        if (tick)               late_nxt  = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state             <= ST_IDLE;
      rd_ptr            <= '0;
      wr_ptr            <= '0;
      level             <= '0;
      m_axis_data_tdata <= '0;
      underrun          <= 1'b0;
      late              <= 1'b0;
    end else begin
      state    <= state_nxt;
      underrun <= underrun_nxt;
      late     <= late_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr            <= rd_ptr + PW'(1);
        m_axis_data_tdata <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= s_axis_data_tdata;
  end

endmodule

// File: tb/tb_audio_sample_pacer.sv
// Directed bench for audio_sample_pacer at CLK_HZ=10, FS_HZ=3, DEPTH=4, plus a default-rate tick smoke check.
module tb_audio_sample_pacer;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        s_vld = 1'b0;
  logic        s_rdy;
  logic [15:0] s_dat = '0;
  logic        m_vld;
  logic        m_rdy = 1'b0;
  logic [15:0] m_dat;
  logic [2:0]  level;
  logic        underrun;
  logic        late;
  logic        smoke_tick;

  int n_vec = 0;
  int n_bad = 0;

  always #5 aclk = ~aclk;

  audio_sample_pacer #(
    .DATA_W (16),
    .DEPTH  (4),
    .CLK_HZ (10),
    .FS_HZ  (3)
  ) dut (
    .aclk               (aclk),
    .areset             (areset),
    .s_axis_data_tvalid (s_vld),
    .s_axis_data_tready (s_rdy),
    .s_axis_data_tdata  (s_dat),
    .m_axis_data_tvalid (m_vld),
    .m_axis_data_tready (m_rdy),
    .m_axis_data_tdata  (m_dat),
    .fifo_level         (level),
    .underrun           (underrun),
    .late               (late)
  );

  fs_tick_gen #(
    .CLK_HZ (50_000_000),
    .FS_HZ  (44_100)
  ) u_smoke (
    .aclk   (aclk),
    .areset (areset),
    .tick   (smoke_tick)
  );

  typedef struct {
    logic        s_vld;
    logic [15:0] s_dat;
    logic        m_rdy;
    logic        e_mvld;
    logic [15:0] e_mdat;
    logic        e_srdy;
    logic [2:0]  e_lvl;
    logic        e_und;
    logic        e_late;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(input logic sv, input logic [15:0] sd, input logic mr,
                              input logic ev, input logic [15:0] ed, input logic er,
                              input logic [2:0] el, input logic eu, input logic elt);
    vec_t v;
    v.s_vld = sv; v.s_dat = sd; v.m_rdy = mr;
    v.e_mvld = ev; v.e_mdat = ed; v.e_srdy = er; v.e_lvl = el; v.e_und = eu; v.e_late = elt;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs set now are sampled at the next edge; outputs read 1 time unit after it.
  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1; s_vld = 1'b0; s_dat = '0; m_rdy = 1'b0;
    cyc();
    cyc();
    areset = 1'b0;
  endtask

  initial begin
    int und_cnt;
    int vld_cnt;
    int pops;
    int ticks;
    int last;
    logic [15:0] d;
    logic prev_srdy;
    logic [15:0] q [$];
    logic e_mvld;
    logic e_late;
    logic [2:0] e_lvl;

    // burst then pace: cycle-by-cycle expectations
    tbl[0]  = mk(1'b1, 16'h0001, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd1, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 16'h0002, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd2, 1'b0, 1'b0);
    tbl[2]  = mk(1'b1, 16'h0003, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd3, 1'b0, 1'b0);
    tbl[3]  = mk(1'b1, 16'h0004, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd4, 1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0001, 1'b1, 3'd3, 1'b0, 1'b0);
    tbl[5]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd3, 1'b0, 1'b0);
    tbl[6]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd3, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 1'b1, 3'd2, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd2, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd2, 1'b0, 1'b0);
    tbl[10] = mk(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0003, 1'b1, 3'd1, 1'b0, 1'b0);
    tbl[11] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd1, 1'b0, 1'b0);
    tbl[12] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd1, 1'b0, 1'b0);
    tbl[13] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd1, 1'b0, 1'b0);
    tbl[14] = mk(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 1'b1, 3'd0, 1'b0, 1'b0);
    tbl[15] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd0, 1'b0, 1'b0);
    tbl[16] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd0, 1'b0, 1'b0);
    tbl[17] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd0, 1'b1, 1'b0);

    // reset state
    do_reset();
    chk("rst_mvld", int'(m_vld), 0);
    chk("rst_mdat", int'(m_dat), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_srdy", int'(s_rdy), 1);
    chk("rst_underrun", int'(underrun), 0);
    chk("rst_late", int'(late), 0);

    // tick cadence observed through underrun on an idle, empty pacer
    do_reset();
    und_cnt = 0;
    vld_cnt = 0;
    for (int k = 1; k <= 1001; k++) begin
      cyc();
      if (k <= 21)
        chk($sformatf("cadence_und_c%0d", k), int'(underrun),
            (k == 5 || k == 8 || k == 11 || k == 15 || k == 18 || k == 21) ? 1 : 0);
      if (underrun) und_cnt++;
      if (m_vld) vld_cnt++;
    end
    chk("ticks_per_1000", und_cnt, 300);
    chk("underrun_no_valid", vld_cnt, 0);

    // burst then pace
    do_reset();
    for (int i = 0; i < 18; i++) begin
      s_vld = tbl[i].s_vld;
      s_dat = tbl[i].s_dat;
      m_rdy = tbl[i].m_rdy;
      cyc();
      chk($sformatf("pace_mvld_c%0d", i + 1), int'(m_vld), int'(tbl[i].e_mvld));
      if (tbl[i].e_mvld)
        chk($sformatf("pace_mdat_c%0d", i + 1), int'(m_dat), int'(tbl[i].e_mdat));
      chk($sformatf("pace_srdy_c%0d", i + 1), int'(s_rdy), int'(tbl[i].e_srdy));
      chk($sformatf("pace_level_c%0d", i + 1), int'(level), int'(tbl[i].e_lvl));
      chk($sformatf("pace_und_c%0d", i + 1), int'(underrun), int'(tbl[i].e_und));
      chk($sformatf("pace_late_c%0d", i + 1), int'(late), int'(tbl[i].e_late));
    end

    // backpressure: stall through tick 7, release on the cycle that sees tick 10
    do_reset();
    m_rdy = 1'b0;
    s_vld = 1'b1; s_dat = 16'hABCD;
    cyc();
    s_dat = 16'h1234;
    cyc();
    chk("bp_level_c2", int'(level), 2);
    s_vld = 1'b0;
    for (int k = 3; k <= 16; k++) begin
      m_rdy = (k >= 11);
      cyc();
      e_mvld = (k >= 5 && k <= 10) || k == 15;
      e_late = (k == 8 || k == 11);
      e_lvl  = (k <= 4) ? 3'd2 : (k <= 14) ? 3'd1 : 3'd0;
      chk($sformatf("bp_mvld_c%0d", k), int'(m_vld), int'(e_mvld));
      chk($sformatf("bp_late_c%0d", k), int'(late), int'(e_late));
      chk($sformatf("bp_level_c%0d", k), int'(level), int'(e_lvl));
      if (e_mvld)
        chk($sformatf("bp_mdat_c%0d", k), int'(m_dat), (k == 15) ? 32'h1234 : 32'hABCD);
    end

    // full boundary with s_vld held high, scoreboarded data order
    do_reset();
    m_rdy = 1'b1;
    s_vld = 1'b1;
    d = 16'h0100;
    prev_srdy = 1'b1;
    pops = 0;
    q.delete();
    for (int k = 1; k <= 40; k++) begin
      s_dat = d;
      cyc();
      if (prev_srdy) q.push_back(d);
      d++;
      chk($sformatf("full_lvl_le4_c%0d", k), int'(level <= 3'd4), 1);
      chk($sformatf("full_srdy_c%0d", k), int'(s_rdy), int'(level != 3'd4));
      if (k == 4) chk("full_level_c4", int'(level), 4);
      if (m_vld) begin
        pops++;
        if (q.size() == 0) chk($sformatf("full_pop_nodata_c%0d", k), 1, 0);
        else chk($sformatf("full_mdat_c%0d", k), int'(m_dat), int'(q.pop_front()));
      end
      prev_srdy = s_rdy;
    end
    chk("full_pop_count", pops, 11);

    // reset mid-stream during HOLD with level 3
    do_reset();
    m_rdy = 1'b0;
    s_vld = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      s_dat = 16'(16'h0050 + k);
      cyc();
    end
    s_vld = 1'b0;
    cyc();
    chk("mid_pre_mvld", int'(m_vld), 1);
    chk("mid_pre_level", int'(level), 3);
    areset = 1'b1;
    cyc();
    chk("mid_rst_mvld", int'(m_vld), 0);
    chk("mid_rst_mdat", int'(m_dat), 0);
    chk("mid_rst_level", int'(level), 0);
    chk("mid_rst_srdy", int'(s_rdy), 1);
    chk("mid_rst_und", int'(underrun), 0);
    chk("mid_rst_late", int'(late), 0);
    areset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk($sformatf("mid_after_und_c%0d", k), int'(underrun), (k == 5) ? 1 : 0);
      chk($sformatf("mid_after_mvld_c%0d", k), int'(m_vld), 0);
    end

    // default-rate tick spacing
    do_reset();
    ticks = 0;
    last = 0;
    for (int k = 1; k <= 13000 && ticks < 11; k++) begin
      cyc();
      if (smoke_tick) begin
        if (ticks == 0) chk("smoke_first_tick", k, 1134);
        else chk($sformatf("smoke_spacing_%0d(%0d)", ticks, k - last),
                 int'((k - last) == 1133 || (k - last) == 1134), 1);
        last = k;
        ticks++;
      end
    end
    chk("smoke_tick_count", ticks, 11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
